of_unit: RTL and testbench

- Operand-fetch stage directly downstream of the instruction-fetch unit in the SimpleRisc core.
- Latches the fetched PC and instruction into an IF/OF pipeline register.
- Decodes register specifiers and reads a 16x32 register file with two read ports and one write-back port.
- Produces the extended immediate and the branch target consumed by the execute stage and by the fetch unit's branch input.

---
 rtl/of_unit.sv | 138 +++++++++++++
 tb/tb_of_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/of_unit.sv
// of_unit: SimpleRisc operand-fetch stage.
// IF/OF pipeline latch, 16x32 register file (two read ports, one write port),
// immediate extension and branch-target computation.
// Optional feature: define WB_BYPASS_EN to forward same-cycle write-back data
// onto op1/op2 when the write address matches a read address.
module of_unit #(
    parameter int          DATA_W   = 32,
    parameter int          NUM_REGS = 16,
    parameter logic [31:0] NOP_INST = 32'h6800_0000,
    parameter int          RA_IDX   = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 if_pc,
    input  logic [31:0]                 if_inst,
    input  logic                        stall,
    input  logic                        flush,
    input  logic                        wb_en,
    input  logic [$clog2(NUM_REGS)-1:0] wb_addr,
    input  logic [DATA_W-1:0]           wb_data,
    output logic [31:0]                 pc_out,
    output logic [31:0]                 inst_out,
    output logic                        valid_out,
    output logic [DATA_W-1:0]           op1,
    output logic [DATA_W-1:0]           op2,
    output logic [31:0]                 immx,
    output logic [31:0]                 branch_target
);

    localparam int            AW      = $clog2(NUM_REGS);
    localparam logic [AW-1:0] RA_ADDR = AW'(RA_IDX);
    localparam logic [4:0]    OP_ST   = 5'b01111;
    localparam logic [4:0]    OP_RET  = 5'b10100;

    // Pipeline latch state and its next-state values
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;

    // Register file storage
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Decoded fields
    logic [4:0]    opcode;
    logic [AW-1:0] rd, rs1, rs2;
    logic [1:0]    imm_mod;
    logic [15:0]   imm16;
    logic [AW-1:0] addr_a, addr_b;

    // Next-state selection for the latch: flush beats stall beats load
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        pc_d    = if_pc;
        inst_d  = if_inst;
        valid_d = 1'b1;
        if (flush) begin
            pc_d    = if_pc;
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (stall) begin
            pc_d    = pc_q;
            inst_d  = inst_q;
            valid_d = valid_q;
        end
    end

    // Latch register with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    // Register file write port; writes are independent of stall and flush
    always_ff @(posedge clk) begin
        // NOTE: this memory is reset because architectural state must read as zero after reset,
        // which forces flops rather than a RAM macro.
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // Field decode and read-address steering (ret reads RA, st reads rd)
    always_comb begin
        opcode  = inst_q[31:27];
        rd      = inst_q[25:22];
        rs1     = inst_q[21:18];
        rs2     = inst_q[17:14];
        imm_mod = inst_q[17:16];
        imm16   = inst_q[15:0];
        addr_a  = (opcode == OP_RET) ? RA_ADDR : rs1;
        addr_b  = (opcode == OP_ST)  ? rd      : rs2;
    end

`ifdef WB_BYPASS_EN
    // Operand read with same-cycle forwarding of write-back data
    always_comb begin
        op1 = (wb_en && (wb_addr == addr_a)) ? wb_data : regs_q[addr_a];
        op2 = (wb_en && (wb_addr == addr_b)) ? wb_data : regs_q[addr_b];
    end
`else
    // Operand read; a same-cycle write is visible only after the edge
    always_comb begin
        op1 = regs_q[addr_a];
        op2 = regs_q[addr_b];
    end
`endif

    // Immediate extension; modifier 11 behaves like sign-extension
    always_comb begin
        unique case (imm_mod)
            2'b01:   immx = {16'h0000, imm16};
            2'b10:   immx = {imm16, 16'h0000};
            default: immx = {{16{imm16[15]}}, imm16};
        endcase
    end

    // Branch target: word offset sign-extended from 27 bits, wraps modulo 2^32
    always_comb begin
        branch_target = pc_q + {{3{inst_q[26]}}, inst_q[26:0], 2'b00};
    end

    assign pc_out    = pc_q;
    assign inst_out  = inst_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_of_unit.sv
// tb_of_unit: scoreboard bench for of_unit. The driver pushes hand-computed
// expectations tagged with the cycle they become visible; a monitor pops and
// compares them on every falling edge after inputs settle.
module tb_of_unit;

    localparam logic [31:0] NOP = 32'h6800_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc, if_inst;
    logic        stall, flush, wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] pc_out, inst_out, op1, op2, immx, branch_target;
    logic        valid_out;

    of_unit dut (
        .clk(clk), .reset(reset), .if_pc(if_pc), .if_inst(if_inst),
        .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .pc_out(pc_out), .inst_out(inst_out),
        .valid_out(valid_out), .op1(op1), .op2(op2), .immx(immx),
        .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    typedef enum {S_PC, S_INST, S_VALID, S_OP1, S_OP2, S_IMMX, S_BT} sig_e;
    typedef struct {
        int unsigned cyc;
        sig_e        sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned ncyc   = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] actual(sig_e s);
        case (s)
            S_PC:    return pc_out;
            S_INST:  return inst_out;
            S_VALID: return {31'b0, valid_out};
            S_OP1:   return op1;
            S_OP2:   return op2;
            S_IMMX:  return immx;
            default: return branch_target;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, ncyc, act, exp);
        end
    endtask

    // Expectation visible d cycles after the current drive point
    task automatic push(int unsigned d, sig_e s, logic [31:0] v, string n);
        exp_t e;
        e.cyc  = ncyc + d;
        e.sig  = s;
        e.val  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    // Advance to the next drive point (falling edge)
    task automatic tick();
        @(negedge clk);
        ncyc++;
    endtask

    task automatic wb(logic en, logic [3:0] a, logic [31:0] d);
        wb_en   = en;
        wb_addr = a;
        wb_data = d;
    endtask

    // Monitor: compare every expectation due in this cycle
    initial begin
        forever begin
            @(negedge clk);
            #2;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == ncyc) begin
                    check(sb[i].name, actual(sb[i].sig), sb[i].val);
                    sb.delete(i);
                end else if (sb[i].cyc < ncyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: expectation for cycle %0d never sampled", sb[i].name, sb[i].cyc);
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; if_pc = '0; if_inst = NOP; stall = 1'b0; flush = 1'b0;
        wb(1'b0, 4'd0, 32'd0);

        tick();                                   // reset edge
        // write R3=5 and read it back through rs1
        tick(); reset = 1'b1; wb(1'b1, 4'd3, 32'd5); if_inst = 32'h000C_0000; if_pc = 32'h4;
        tick(); wb(1'b0, 4'd0, 32'd0);
        push(0, S_OP1, 32'd5, "r3_before_reset");
        // two reset edges; write during reset must be ignored
        tick(); reset = 1'b0; wb(1'b1, 4'd4, 32'hDEAD);
        push(1, S_PC, 32'h0, "reset_pc");
        push(1, S_INST, NOP, "reset_inst");
        push(1, S_VALID, 32'd0, "reset_valid");
        tick(); wb(1'b0, 4'd0, 32'd0);
        tick(); reset = 1'b1; if_inst = 32'h000C_0000; if_pc = 32'h8;
        push(0, S_VALID, 32'd0, "reset_valid_held");
        push(1, S_OP1, 32'd0, "r3_cleared");
        push(1, S_PC, 32'h8, "load_pc");
        // load/read of add r3,r1,r2
        tick(); wb(1'b1, 4'd1, 32'h10); if_inst = 32'h0010_0000; if_pc = 32'hC;
        push(1, S_OP1, 32'd0, "r4_write_in_reset_ignored");
        tick(); wb(1'b1, 4'd2, 32'h20); if_inst = 32'h00C4_8000; if_pc = 32'h40;
        push(1, S_PC, 32'h40, "add_pc");
        push(1, S_INST, 32'h00C4_8000, "add_inst");
        push(1, S_VALID, 32'd1, "add_valid");
        push(1, S_OP1, 32'h10, "add_op1");
        push(1, S_OP2, 32'h20, "add_op2");
        // immediate modifiers
        tick(); wb(1'b0, 4'd0, 32'd0); if_inst = 32'h0000_FFFF; if_pc = 32'h44;
        push(1, S_IMMX, 32'hFFFF_FFFF, "imm_sext");
        tick(); if_inst = 32'h0001_FFFF;
        push(1, S_IMMX, 32'h0000_FFFF, "imm_zext");
        tick(); if_inst = 32'h0002_ABCD;
        push(1, S_IMMX, 32'hABCD_0000, "imm_upper");
        tick(); if_inst = 32'h0003_8001;
        push(1, S_IMMX, 32'hFFFF_8001, "imm_mod11");
        // branch targets
        tick(); if_inst = 32'h97FF_FFFF; if_pc = 32'h100;
        push(1, S_BT, 32'h0000_00FC, "bt_neg");
        tick(); if_inst = 32'h9000_0003; if_pc = 32'h100;
        push(1, S_BT, 32'h0000_010C, "bt_pos");
        tick(); if_inst = 32'h97FF_FFFF; if_pc = 32'h0;
        push(1, S_BT, 32'hFFFF_FFFC, "bt_wrap");
        // stall for three cycles, then stall+flush
        tick(); if_inst = 32'h00C4_8000; if_pc = 32'h200;
        push(1, S_PC, 32'h200, "pre_stall_pc");
        for (int k = 0; k < 3; k++) begin
            tick(); stall = 1'b1; if_inst = 32'h1111_1111; if_pc = 32'h300;
            push(1, S_PC, 32'h200, "stall_pc");
            push(1, S_INST, 32'h00C4_8000, "stall_inst");
            push(1, S_VALID, 32'd1, "stall_valid");
        end
        tick(); stall = 1'b1; flush = 1'b1; if_pc = 32'h304;
        push(1, S_INST, NOP, "flush_inst");
        push(1, S_VALID, 32'd0, "flush_valid");
        push(1, S_PC, 32'h304, "flush_pc");
        // st and ret operand routing
        tick(); stall = 1'b0; flush = 1'b0; wb(1'b1, 4'd5, 32'h77);
        tick(); wb(1'b1, 4'd15, 32'h200); if_inst = 32'h7940_0000; if_pc = 32'h400;
        push(1, S_OP2, 32'h77, "st_op2_rd");
        tick(); wb(1'b0, 4'd0, 32'd0); if_inst = 32'hA000_0000; if_pc = 32'h404;
        push(1, S_OP1, 32'h200, "ret_op1_ra");
        tick(); if_inst = 32'h7940_0000; if_pc = 32'h408;
        // same-cycle write to R5 while st is held by stall
        tick(); stall = 1'b1; wb(1'b1, 4'd5, 32'h99);
`ifdef WB_BYPASS_EN
        push(0, S_OP2, 32'h99, "st_same_cycle_write");
`else
        push(0, S_OP2, 32'h77, "st_same_cycle_write");
`endif
        push(1, S_OP2, 32'h99, "st_after_write");
        // reset in the middle of a stall
        tick(); wb(1'b0, 4'd0, 32'd0); reset = 1'b0;
        push(1, S_PC, 32'h0, "midreset_pc");
        push(1, S_INST, NOP, "midreset_inst");
        push(1, S_VALID, 32'd0, "midreset_valid");
        tick(); reset = 1'b1; stall = 1'b0; if_inst = 32'h7940_0000; if_pc = 32'h500;
        push(1, S_OP2, 32'h0, "midreset_r5_cleared");
        push(1, S_VALID, 32'd1, "post_reset_valid");

        // drain with a bounded wait
        for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
        #3;
        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: expectation still pending at end", sb[0].name);
            void'(sb.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
